// File: rtl/ae_ctrl_pkg.sv
// Shared control definitions for the autoencoder sequencer: opcodes, FSM states, operand fields.
package ae_ctrl_pkg;

    localparam int OPC_LSB = 12;
    localparam int OPC_W   = 4;
    localparam int TGT_LSB = 0;
    localparam int TGT_W   = 5;
    localparam int CNT_LSB = 5;
    localparam int CNT_W   = 7;

    localparam logic [OPC_W-1:0] OP_HALT = 4'hF;
    localparam logic [OPC_W-1:0] OP_JMP  = 4'hE;
    localparam logic [OPC_W-1:0] OP_LOOP = 4'hD;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_DONE
    } seq_state_t;

endpackage

// File: rtl/loop_ctrl.sv
// Single-level loop counter: decides taken/fall-through for each LOOP strobe; state updates one cycle later.
// No backpressure; clr (new program start) wins over a strobe.
module loop_ctrl
    import ae_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             loop_stb,
    input  logic [CNT_W-1:0] loop_n,
    output logic             taken
);

    logic             loop_active;
    logic [CNT_W-1:0] loop_cnt;

    // A LOOP seen while a loop is running only consumes the running count.
    assign taken = loop_active ? (loop_cnt != '0) : (loop_n != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loop_active <= 1'b0;
            loop_cnt    <= '0;
        end else if (clr) begin
            loop_active <= 1'b0;
            loop_cnt    <= '0;
        end else if (loop_stb) begin
            if (!loop_active) begin
                if (loop_n != '0) begin
                    loop_active <= 1'b1;
                    loop_cnt    <= loop_n - CNT_W'(1);
                end
            end else if (loop_cnt != '0) begin
                loop_cnt <= loop_cnt - CNT_W'(1);
            end else begin
                loop_active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode sequencer: 3 cycles per datapath issue, 2 per control op; outputs come from registers only.
// A datapath word is held stable in ISSUE until instr_ready; the PC advances only on the handshake.
module instr_sequencer
    import ae_ctrl_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 5,
    parameter int                    DATA_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] fetch_addr,
    input  logic [DATA_WIDTH-1:0] instr_code,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr_data,
    input  logic                  instr_ready,
    output logic                  busy,
    output logic                  done
);

    seq_state_t            state;
    seq_state_t            state_nxt;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_nxt;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_nxt;
    logic                  loop_stb;
    logic                  loop_clr;
    logic                  loop_taken;

    logic [OPC_W-1:0]      opcode;
    logic [ADDR_WIDTH-1:0] target;
    logic [CNT_W-1:0]      loop_n;
    logic [ADDR_WIDTH-1:0] pc_inc;

    assign opcode = instr_code[OPC_LSB +: OPC_W];
    assign target = ADDR_WIDTH'(instr_code[TGT_LSB +: TGT_W]);
    assign loop_n = instr_code[CNT_LSB +: CNT_W];
    assign pc_inc = pc + ADDR_WIDTH'(1);

    loop_ctrl u_loop_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (loop_clr),
        .loop_stb (loop_stb),
        .loop_n   (loop_n),
        .taken    (loop_taken)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            pc     <= START_ADDR;
            data_q <= '0;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            data_q <= data_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        data_nxt  = data_q;
        loop_stb  = 1'b0;
        loop_clr  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_FETCH;
                    pc_nxt    = START_ADDR;
                    loop_clr  = 1'b1;
                end
            end
            S_FETCH: state_nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_HALT: state_nxt = S_DONE;
                    OP_JMP: begin
                        pc_nxt    = target;
                        state_nxt = S_FETCH;
                    end
                    OP_LOOP: begin
                        loop_stb  = 1'b1;
                        pc_nxt    = loop_taken ? target : pc_inc;
                        state_nxt = S_FETCH;
                    end
                    default: begin
                        data_nxt  = instr_code;
                        state_nxt = S_ISSUE;
                    end
                endcase
            end
            S_ISSUE: begin
                if (instr_ready) begin
                    pc_nxt    = pc_inc;
                    state_nxt = S_FETCH;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign fetch_addr  = pc;
    assign instr_data  = data_q;
    assign instr_valid = (state == S_ISSUE);
    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: instruction-level program interpreter predicts issue order, PCs and gap lengths.
module tb_instr_sequencer;

    localparam int         AW    = 5;
    localparam int         DW    = 16;
    localparam logic [4:0] START = 5'd0;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] fetch_addr;
    logic [DW-1:0] instr_code;
    logic          instr_valid;
    logic [DW-1:0] instr_data;
    logic          instr_ready;
    logic          busy;
    logic          done;

    instr_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .START_ADDR(START)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .fetch_addr  (fetch_addr),
        .instr_code  (instr_code),
        .instr_valid (instr_valid),
        .instr_data  (instr_data),
        .instr_ready (instr_ready),
        .busy        (busy),
        .done        (done)
    );

    logic [15:0] mem [0:31];
    always @(posedge clk) instr_code <= mem[fetch_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One expected event per issued word or final HALT; k = control ops executed since the previous event.
    typedef struct {
        bit          is_done;
        logic [15:0] data;
        logic [4:0]  addr;
        int          k;
    } ev_t;

    ev_t evq[$];
    bit  visited [0:31];
    int  tests = 0;
    int  fails = 0;
    int  run_id = 0;
    int  runs_finished = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic build_model(output bit ok);
        logic [4:0]  pc;
        logic [15:0] w;
        bit          in_loop;
        int          jumps_left;
        int          k;
        ev_t         e;
        evq.delete();
        foreach (visited[i]) visited[i] = 1'b0;
        pc = START; in_loop = 0; jumps_left = 0; k = 0; ok = 0;
        for (int s = 0; s < 300 && !ok; s++) begin
            w = mem[pc];
            visited[pc] = 1'b1;
            if (w[15:12] == 4'hF) begin
                e.is_done = 1; e.data = '0; e.addr = pc; e.k = k;
                evq.push_back(e);
                ok = 1;
            end else if (w[15:12] == 4'hE) begin
                pc = w[4:0];
                k++;
            end else if (w[15:12] == 4'hD) begin
                // First encounter arms N back-jumps; each later encounter spends one or exits.
                if (!in_loop) begin
                    in_loop    = (w[11:5] != 7'd0);
                    jumps_left = int'(w[11:5]);
                end
                if (jumps_left > 0) begin
                    jumps_left--;
                    pc = w[4:0];
                end else begin
                    in_loop = 0;
                    pc = pc + 5'd1;
                end
                k++;
            end else begin
                e.is_done = 0; e.data = w; e.addr = pc; e.k = k;
                evq.push_back(e);
                k = 0;
                pc = pc + 5'd1;
            end
        end
    endtask

    // Cycle-level compare: event n is due 2k+2 edges after the previous handshake (or the start edge).
    initial begin : compare
        int   m;
        int   seen_run;
        bit   armed;
        bit   exp_v;
        bit   exp_d;
        ev_t  e;
        m = 0; seen_run = 0; armed = 0;
        forever begin
            @(negedge clk);
            if (run_id != seen_run) begin
                seen_run = run_id;
                m = 0;
                armed = 1;
            end
            if (armed && rst_n) begin
                if (evq.size() == 0) begin
                    check("event_queue_nonempty", 32'(0), 32'(1));
                    armed = 0;
                end else begin
                    e = evq[0];
                    exp_v = !e.is_done && (m >= 2 * e.k + 2);
                    exp_d = e.is_done && (m == 2 * e.k + 2);
                    check("instr_valid", 32'(instr_valid), 32'(exp_v));
                    check("done", 32'(done), 32'(exp_d));
                    check("busy_running", 32'(busy), 32'(1));
                    check("fetch_addr_on_path", 32'(visited[fetch_addr]), 32'(1));
                    if (exp_v) begin
                        check("instr_data", 32'(instr_data), 32'(e.data));
                        check("issue_pc", 32'(fetch_addr), 32'(e.addr));
                        if (instr_ready) begin
                            void'(evq.pop_front());
                            m = -1;
                        end
                    end
                    if (exp_d) begin
                        check("halt_pc", 32'(fetch_addr), 32'(e.addr));
                        void'(evq.pop_front());
                        armed = 0;
                        runs_finished++;
                    end
                    m++;
                end
            end
        end
    end

    task automatic finish_now();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    endtask

    task automatic prepare(input string tag);
        bit ok;
        build_model(ok);
        check({tag, "_model_halts"}, 32'(ok), 32'(1));
    endtask

    // mode 0: ready always 1; mode 1: random ready and stray start; mode 2: stall first issue 5 cycles.
    task automatic launch(input int mode, input string tag);
        int target;
        int cyc;
        int stall;
        target = runs_finished + 1;
        stall = 5;
        @(negedge clk);
        start = 1'b1;
        instr_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        run_id++;
        cyc = 0;
        while (runs_finished < target && cyc < 3000) begin
            if (mode == 1) begin
                instr_ready = ($urandom_range(0, 3) != 0);
                start = ($urandom_range(0, 1) == 1);
            end else if (mode == 2 && instr_valid && stall > 0) begin
                instr_ready = 1'b0;
                stall--;
            end else begin
                instr_ready = 1'b1;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        instr_ready = 1'b0;
        check({tag, "_completes"}, 32'(runs_finished), 32'(target));
        if (runs_finished < target) finish_now();
        @(negedge clk);
        check({tag, "_busy_after_done"}, 32'(busy), 32'(0));
        check({tag, "_done_single_pulse"}, 32'(done), 32'(0));
    endtask

    task automatic clear_mem();
        foreach (mem[i]) mem[i] = 16'hF000;
    endtask

    task automatic manual_start();
        @(negedge clk);
        start = 1'b1;
        instr_ready = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 50 && !instr_valid; i++) @(negedge clk);
        @(negedge clk);
    endtask

    initial begin : stim
        int n3001;
        bit ok;
        start = 1'b0;
        instr_ready = 1'b0;
        rst_n = 1'b1;
        clear_mem();
        #1 rst_n = 1'b0;
        #1;
        check("rst_fetch_addr", 32'(fetch_addr), 32'(START));
        check("rst_instr_valid", 32'(instr_valid), 32'(0));
        check("rst_instr_data", 32'(instr_data), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Straight-line program, then the same with a 5-cycle stall on the first issue.
        mem[0] = 16'h1001; mem[1] = 16'h1002; mem[2] = 16'h1003; mem[3] = 16'hF000;
        prepare("seq");
        check("seq_model_events", 32'(evq.size()), 32'(4));
        check("seq_model_third", 32'(evq[2].data), 32'(16'h1003));
        check("seq_model_halt_gap", 32'(evq[3].k), 32'(0));
        launch(0, "seq");
        prepare("stall");
        launch(2, "stall");

        // Reset while a word sits in ISSUE after a JMP; then a clean rerun of the JMP program.
        clear_mem();
        mem[0] = 16'hE005; mem[5] = 16'h2AAA; mem[6] = 16'hF000;
        manual_start();
        check("pre_reset_valid", 32'(instr_valid), 32'(1));
        check("pre_reset_pc", 32'(fetch_addr), 32'(5));
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(instr_valid), 32'(0));
        check("async_rst_busy", 32'(busy), 32'(0));
        check("async_rst_fetch_addr", 32'(fetch_addr), 32'(START));
        check("async_rst_data", 32'(instr_data), 32'(0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("in_reset_no_done", 32'(done), 32'(0));
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_no_done", 32'(done), 32'(0));
        prepare("jmp");
        check("jmp_model_events", 32'(evq.size()), 32'(2));
        check("jmp_model_word", 32'(evq[0].data), 32'(16'h2AAA));
        check("jmp_model_skips_1_4", 32'({visited[1], visited[2], visited[3], visited[4]}), 32'(0));
        launch(0, "jmp");

        // Loop body runs N+1 = 3 times.
        clear_mem();
        mem[0] = 16'h3001; mem[1] = 16'hD040; mem[2] = 16'hF000;
        prepare("loop");
        n3001 = 0;
        foreach (evq[i]) if (!evq[i].is_done && evq[i].data == 16'h3001) n3001++;
        check("loop_model_body_count", 32'(n3001), 32'(3));
        check("loop_model_exit_gap", 32'(evq[3].k), 32'(1));
        launch(1, "loop");

        // PC wrap 31 -> 0; address 0 is rewritten to HALT while 0x4444 is stalled.
        clear_mem();
        mem[0] = 16'hE01F; mem[31] = 16'h4444;
        manual_start();
        check("wrap_issue_data", 32'(instr_data), 32'(16'h4444));
        check("wrap_issue_pc", 32'(fetch_addr), 32'(31));
        mem[0] = 16'hF000;
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        check("wrap_pc_zero", 32'(fetch_addr), 32'(0));
        check("wrap_valid_drop", 32'(instr_valid), 32'(0));
        @(negedge clk);
        check("wrap_no_early_done", 32'(done), 32'(0));
        @(negedge clk);
        check("wrap_done", 32'(done), 32'(1));
        @(negedge clk);
        check("wrap_idle", 32'(busy), 32'(0));

        // Random programs with random backpressure and stray start pulses.
        for (int r = 0; r < 25; r++) begin
            ok = 0;
            for (int t = 0; t < 100 && !ok; t++) begin
                for (int a = 0; a < 32; a++) begin
                    int sel;
                    sel = $urandom_range(0, 99);
                    if (sel < 55)      mem[a] = {4'($urandom_range(0, 12)), 12'($urandom)};
                    else if (sel < 65) mem[a] = {4'hE, 12'($urandom)};
                    else if (sel < 80) mem[a] = {4'hD, 7'($urandom_range(0, 3)), 5'($urandom)};
                    else               mem[a] = {4'hF, 12'($urandom)};
                end
                build_model(ok);
            end
            prepare("rand");
            if (ok) launch(1, "rand");
        end

        finish_now();
    end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Program sequencer for the autoencoder's instruction memory. Drives the 5-bit fetch address into the synchronous-read instruction memory (one-cycle read latency) and decodes each 16-bit instruction word. Executes control opcodes (HALT, JMP, LOOP) internally and issues all other words to the datapath over a valid/ready handshake. Sits between the top-level start/done control and the datapath, replacing the free-running address counter.

## Interface
- `ADDR_WIDTH`, default 5: fetch address width; matches the memory counter port.
- `DATA_WIDTH`, default 16: instruction word width.
- `START_ADDR`, default 0: PC value after reset and on each start.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low. This is the only reset.
- `start`  in  1  level-sampled; accepted only in IDLE.
- `fetch_addr`  out  ADDR_WIDTH  connects to the memory `counter` input; equals the PC register.
- `instr_code`  in  DATA_WIDTH  word from memory; valid one cycle after `fetch_addr`.
- `instr_valid`  out  1  a datapath instruction is presented.
- `instr_data`  out  DATA_WIDTH  the instruction presented; stable while `instr_valid` is high.
- `instr_ready`  in  1  datapath accepts the instruction.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after HALT.

## Operation
- Instruction format: [15:12] opcode, [11:0] operand.
- HALT = 4'hF.
- JMP = 4'hE: target = operand[4:0].
- LOOP = 4'hD: target = operand[4:0], count N = operand[11:5] (7 bits).
- All other opcodes are datapath instructions and are forwarded unmodified.
- FSM states: IDLE, FETCH, DECODE, ISSUE, DONE.
- IDLE: if `start` = 1, set PC ← START_ADDR and go to FETCH. Otherwise stay in IDLE.
- FETCH: `fetch_addr` = PC; the memory captures it. Always go to DECODE.
- DECODE (`instr_code` is valid here):
  - HALT: go to DONE.
  - JMP: PC ← target; go to FETCH.
  - LOOP: apply the loop rules below; go to FETCH.
  - Datapath op: `instr_data` ← `instr_code`; go to ISSUE.
- ISSUE: `instr_valid` = 1. When `instr_ready` = 1, PC ← PC+1 and go to FETCH. Otherwise hold; `instr_data` must not change.
- DONE: `done` = 1 for this one cycle; go to IDLE.
- LOOP rules (single level; state is `loop_active` and a 7-bit `loop_cnt`, both reset to 0):
  - Inactive, N ≠ 0: `loop_cnt` ← N−1, `loop_active` ← 1, PC ← target.
  - Inactive, N = 0: PC ← PC+1 (no-op).
  - Active, `loop_cnt` ≠ 0: `loop_cnt` ← `loop_cnt`−1, PC ← target.
  - Active, `loop_cnt` = 0: `loop_active` ← 0, PC ← PC+1.
  - Net effect: the body runs N+1 times.
  - A LOOP inside a running loop behaves as the outer loop's counter. Nesting is not supported.
  - `start` clears `loop_active` and `loop_cnt`.
- PC arithmetic: modulo 2^ADDR_WIDTH. PC = 31 plus 1 wraps to 0 with no error flag.
- `start` outside IDLE is ignored.
- `instr_ready` outside ISSUE is ignored.

## Timing
- Reset values:
  - state = IDLE, PC = START_ADDR, so `fetch_addr` = START_ADDR.
  - `instr_valid` = 0, `instr_data` = 0, `busy` = 0, `done` = 0.
  - `loop_active` = 0, `loop_cnt` = 0.
- All outputs are registered or decoded from the state register only. No combinational path from any input to any output.
- Start latency: `start` is sampled at edge E0. State is FETCH after E0, DECODE after E1, ISSUE after E2. `instr_valid` first goes high after E2.
- Throughput without stall: 3 cycles per datapath instruction. Control ops take 2 cycles each (FETCH + DECODE).
- HALT: DONE in the cycle after its DECODE; `busy` falls in the cycle after that.
- Handshake: transfer occurs on an edge where `instr_valid` and `instr_ready` are both high. `instr_valid` drops on the next cycle (FETCH).
- Reset asserted mid-operation (any state): all registers return to reset values immediately, asynchronously. An in-flight instruction is dropped and no `done` pulse is produced.

## Structure
- Shared package `ae_ctrl_pkg` holds:
  - opcode constants `OP_HALT`, `OP_JMP`, `OP_LOOP`;
  - the state enum `seq_state_t`;
  - operand field position/width constants.
- Optional sub-module `loop_ctrl`: owns `loop_active` and `loop_cnt`. It takes a LOOP strobe and N, and returns a taken/fall-through decision.

## Test plan
- Program: 0x1001, 0x1002, 0x1003, 0xF000 at 0..3, `instr_ready` tied to 1. Expect three issues in that order, 3 cycles apart. Expect `done` pulse 2 cycles after the 0x1003 handshake.
- Backpressure: hold `instr_ready` = 0 for 5 cycles while 0x1001 is presented. Expect `instr_valid` and `instr_data` stable for all 5 cycles and PC unchanged.
- JMP: 0xE005 at 0, 0x2AAA at 5, 0xF000 at 6. Expect only 0x2AAA issued and no fetch of addresses 1–4.
- LOOP: body 0x3001 at 0, LOOP with N = 2 and target 0 (0xD040) at 1, HALT at 2. Expect 0x3001 issued exactly 3 times, then `done`.
- Wrap: JMP to 31 where address 31 holds 0x4444 and address 0 holds HALT. Expect PC 31 → 0 after the handshake, then `done`.
- Reset mid-ISSUE: deassert `rst_n` while `instr_valid` = 1. Expect `instr_valid`, `busy` and `fetch_addr` at reset values with no clock edge. Expect no `done` pulse, and a clean restart on the next `start`.
